// File: rtl/epp_host_if.sv
// Command/response channel between on-chip logic and the EPP host.
// master = command issuer, slave = epp_host.
interface epp_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_is_addr;
  logic       cmd_write;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;

  modport master (
    output cmd_valid, cmd_is_addr, cmd_write, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_is_addr, cmd_write, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
  );
endinterface

// File: rtl/epp_host.sv
// EPP host: runs one address/data read or write per command on the
// Astb/Dstb/Wr/Db/Wait handshake and returns one response per command.
module epp_host #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  epp_host_if.slave  host,
  inout  wire  [7:0] Db,
  output logic       Astb,
  output logic       Dstb,
  output logic       Wr,
  input  logic       Wait
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RELEASE, DONE} state_e;

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SYNC_STAGES-1:0]      wait_sync_q, wait_sync_d;
  logic [SYNC_STAGES-1:0][7:0] db_sync_q, db_sync_d;
  logic       is_addr_q, is_addr_d, write_q, write_d, tmo_q, tmo_d;
  logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic       astb_q, astb_d, dstb_q, dstb_d, wr_q, wr_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       wait_s;
  logic [7:0] db_s;

  assign wait_sync_d = {wait_sync_q[SYNC_STAGES-2:0], Wait};
  assign db_sync_d   = {db_sync_q[SYNC_STAGES-2:0], Db};
  assign wait_s      = wait_sync_q[SYNC_STAGES-1];
  assign db_s        = db_sync_q[SYNC_STAGES-1];
  assign cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // The data bus drive enable is the registered Wr itself.
  assign Db   = wr_q ? 'z : wdata_q;
  assign Astb = astb_q;
  assign Dstb = dstb_q;
  assign Wr   = wr_q;

  assign host.cmd_ready   = rst | (state_q == IDLE);
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_rdata   = rsp_rdata_q;
  assign host.rsp_timeout = rsp_timeout_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (host.cmd_valid) state_d = SETUP;
      SETUP:   if (cnt_q == SETUP_LAST) state_d = STROBE;
      STROBE:  if (wait_s) state_d = write_q ? RELEASE : CAPTURE;
               else if (cnt_q == TMO_LAST) state_d = RELEASE;
      CAPTURE: state_d = RELEASE;
      RELEASE: if (!wait_s || cnt_q == TMO_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_inc;
    is_addr_d     = is_addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    tmo_d         = tmo_q;
    astb_d        = astb_q;
    dstb_d        = dstb_q;
    wr_d          = wr_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_timeout_d = 1'b0;
    unique case (state_q)
      IDLE: if (host.cmd_valid) begin
        is_addr_d = host.cmd_is_addr;
        write_d   = host.cmd_write;
        wdata_d   = host.cmd_wdata;
        wr_d      = ~host.cmd_write;
        rdata_d   = '0;
        tmo_d     = 1'b0;
        cnt_d     = '0;
      end
      SETUP: if (cnt_q == SETUP_LAST) begin
        astb_d = ~is_addr_q;
        dstb_d = is_addr_q;
        cnt_d  = '0;
      end
      STROBE: begin
        if (wait_s) begin
          if (write_q) begin
            astb_d = 1'b1;
            dstb_d = 1'b1;
            cnt_d  = '0;
          end
        end else if (cnt_q == TMO_LAST) begin
          tmo_d  = 1'b1;
          astb_d = 1'b1;
          dstb_d = 1'b1;
          cnt_d  = '0;
        end
      end
      CAPTURE: begin
        rdata_d = db_s;
        astb_d  = 1'b1;
        dstb_d  = 1'b1;
        cnt_d   = '0;
      end
      // Response is registered on the way into DONE so it is visible during DONE.
      RELEASE: if (!wait_s || cnt_q == TMO_LAST) begin
        tmo_d         = tmo_q | wait_s;
        wr_d          = 1'b1;
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = tmo_q | wait_s;
        rsp_rdata_d   = (!write_q && !(tmo_q | wait_s)) ? rdata_q : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      wait_sync_q   <= '0;
      db_sync_q     <= '0;
      is_addr_q     <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      tmo_q         <= 1'b0;
      astb_q        <= 1'b1;
      dstb_q        <= 1'b1;
      wr_q          <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      wait_sync_q   <= wait_sync_d;
      db_sync_q     <= db_sync_d;
      is_addr_q     <= is_addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      tmo_q         <= tmo_d;
      astb_q        <= astb_d;
      dstb_q        <= dstb_d;
      wr_q          <= wr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_epp_host.sv
// Self-checking bench for epp_host: behavioural EPP peripheral, bus monitor
// and a response scoreboard.
module tb_epp_host;
  localparam int unsigned SETUP = 2;
  localparam int unsigned TMO   = 8;
  localparam int unsigned SYNC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  epp_host_if host_if();
  wire  [7:0] Db;
  logic       Astb, Dstb, Wr;
  logic       Wait = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  epp_host #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .host(host_if),
    .Db(Db), .Astb(Astb), .Dstb(Dstb), .Wr(Wr), .Wait(Wait)
  );

  // Peripheral drives the bus only while the host has Wr high and a cycle is active.
  assign Db = (Wr && (!Astb || !Dstb || Wait)) ? rd_byte : 'z;

  typedef struct { logic [7:0] rdata; logic timeout; } rsp_t;
  rsp_t exp_q[$];

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, accept_cyc = 0, rsp_cyc = 0, rsp_count = 0;
  int unsigned low_cnt = 0, last_low_len = 0;
  logic [7:0] exp_wdata = 8'h00;
  logic exp_is_addr = 1'b0, exp_write = 1'b0;
  logic prev_low = 1'b0, prev_wr = 1'b1;
  int unsigned resp_mode = 0;  // 0: 3-clk delays, 1: Wait stuck 0, 2: Wait stuck 1, 3: instant

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin : responder
    int unsigned dly;
    logic s_low;
    dly = 0;
    forever begin
      @(negedge clk);
      s_low = !Astb || !Dstb;
      case (resp_mode)
        0: begin
          if (s_low != Wait) begin
            if (dly == 2) begin Wait = s_low; dly = 0; end
            else dly++;
          end else dly = 0;
        end
        1: Wait = 1'b0;
        2: if (s_low) Wait = 1'b1;
        default: Wait = s_low;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    logic s_low;
    s_low = !Astb || !Dstb;
    if (!rst) begin
      if (s_low) begin
        check_eq("strobe_overlap", 32'(Astb | Dstb), 1);
        check_eq("ready_busy", 32'(host_if.cmd_ready), 0);
        if (prev_low) check_eq("wr_stable", 32'(Wr), 32'(prev_wr));
        else begin
          check_eq("setup_len", cyc - accept_cyc, SETUP);
          check_eq("strobe_sel", 32'(Astb), 32'(!exp_is_addr));
          check_eq("wr_at_strobe", 32'(Wr), 32'(!exp_write));
        end
        low_cnt++;
      end else begin
        if (prev_low) last_low_len = low_cnt;
        low_cnt = 0;
      end
      if (!Wr) check_eq("db_drive", 32'(Db), 32'(exp_wdata));
      if (host_if.cmd_ready) check_eq("idle_strobes", 32'({Astb, Dstb}), 3);
      if (host_if.rsp_valid) begin
        rsp_cyc = cyc;
        rsp_count++;
        if (exp_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
        else begin
          rsp_t e;
          e = exp_q.pop_front();
          check_eq("rsp_rdata", 32'(host_if.rsp_rdata), 32'(e.rdata));
          check_eq("rsp_timeout", 32'(host_if.rsp_timeout), 32'(e.timeout));
        end
      end
    end else low_cnt = 0;
    prev_low = s_low;
    prev_wr  = Wr;
  end

  task automatic issue(input logic a, input logic w, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input logic exp_to, input logic hold);
    int unsigned n;
    rsp_t e;
    host_if.cmd_valid   = 1'b1;
    host_if.cmd_is_addr = a;
    host_if.cmd_write   = w;
    host_if.cmd_wdata   = wd;
    n = 0;
    while (!host_if.cmd_ready && n < 500) begin @(negedge clk); n++; end
    check_eq("accept_bound", 32'(n < 500), 1);
    e.rdata = exp_rd;
    e.timeout = exp_to;
    exp_q.push_back(e);
    exp_wdata   = wd;
    exp_is_addr = a;
    exp_write   = w;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    if (!hold) host_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check_eq("rsp_bound", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int unsigned n;
    host_if.cmd_valid = 1'b0; host_if.cmd_is_addr = 1'b0;
    host_if.cmd_write = 1'b0; host_if.cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_astb", 32'(Astb), 1);
    check_eq("rst_dstb", 32'(Dstb), 1);
    check_eq("rst_wr", 32'(Wr), 1);
    check_eq("rst_rsp_valid", 32'(host_if.rsp_valid), 0);
    check_eq("rst_rsp_rdata", 32'(host_if.rsp_rdata), 0);
    check_eq("rst_rsp_timeout", 32'(host_if.rsp_timeout), 0);
    check_eq("rst_ready", 32'(host_if.cmd_ready), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Address write with a 3-clock responder.
    resp_mode = 0;
    issue(1'b1, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0);
    wait_rsp();
    repeat (6) @(negedge clk);

    // Instant responder: write then read, with minimum latency.
    resp_mode = 3;
    issue(1'b0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0);
    wait_rsp();
    check_eq("latency_wr", rsp_cyc - accept_cyc + 1, SETUP + 2 * SYNC + 3);
    repeat (3) @(negedge clk);
    rd_byte = 8'hC3;
    issue(1'b0, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b0);
    wait_rsp();
    check_eq("latency_rd", rsp_cyc - accept_cyc + 1, SETUP + 2 * SYNC + 4);
    repeat (3) @(negedge clk);

    // Wait stuck low: strobe held exactly TMO clocks.
    resp_mode = 1;
    issue(1'b0, 1'b1, 8'h11, 8'h00, 1'b1, 1'b0);
    wait_rsp();
    check_eq("strobe_tmo_len", last_low_len, TMO);
    check_eq("tmo_idle", 32'(host_if.cmd_ready), 1);

    // Wait stuck high: handshake accepted, release phase times out.
    resp_mode = 2;
    rd_byte = 8'h99;
    issue(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_rsp();
    check_eq("stuck1_strobes", 32'({Astb, Dstb}), 3);
    check_eq("stuck1_wr", 32'(Wr), 1);
    resp_mode = 0;
    repeat (8) @(negedge clk);

    // Back-to-back with cmd_valid held.
    rd_byte = 8'h42;
    issue(1'b1, 1'b1, 8'h03, 8'h00, 1'b0, 1'b1);
    issue(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 8'h00, 8'h42, 1'b0, 1'b0);
    wait_rsp();
    check_eq("b2b_count", rsp_count, 8);
    repeat (6) @(negedge clk);

    // Reset during STROBE of a write.
    resp_mode = 1;
    issue(1'b0, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b0);
    n = 0;
    while (Dstb && n < 50) begin @(negedge clk); n++; end
    check_eq("strobe_bound", 32'(n < 50), 1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_eq("mid_rst_astb", 32'(Astb), 1);
    check_eq("mid_rst_dstb", 32'(Dstb), 1);
    check_eq("mid_rst_wr", 32'(Wr), 1);
    check_eq("mid_rst_rsp", 32'(host_if.rsp_valid), 0);
    check_eq("mid_rst_ready", 32'(host_if.cmd_ready), 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("no_rsp_after_rst", rsp_count, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/epp_host.md
Name: epp_host

Overview:
- EPP initiator (host side) of the parallel-port EPP interface.
- Accepts single address/data read/write commands from on-chip logic over a valid/ready interface and drives Astb/Dstb/Wr/Db toward an EPP peripheral.
- Completes each transfer on the peripheral's Wait handshake and returns one response per command.
- Used to exercise our EPP peripheral logic in-system and board-to-board, and to talk to external EPP devices.

Parameters:
- SETUP_CYCLES, 2: clocks Wr/Db are driven before the strobe asserts (min 1).
- TIMEOUT_CYCLES, 1000: max clocks waiting for any single Wait edge before aborting (min 4).
- SYNC_STAGES, 2: flip-flop stages on the Wait and Db inputs (min 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high when a command can be accepted (state IDLE)
- cmd_is_addr  input  1  1 = address cycle (Astb), 0 = data cycle (Dstb)
- cmd_write  input  1  1 = host write, 0 = host read
- cmd_wdata  input  8  write byte
- rsp_valid  output  1  one-cycle pulse, transfer finished
- rsp_rdata  output  8  read byte (0 for writes and timeouts)
- rsp_timeout  output  1  valid with rsp_valid; transfer aborted
- Db  inout  8  EPP data bus, driven only while Wr is low
- Astb  output  1  address strobe, active low
- Dstb  output  1  data strobe, active low
- Wr  output  1  write enable, low = host writes
- Wait  input  1  peripheral strobe response, asynchronous

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE; Astb=1, Dstb=1, Wr=1, Db=Z, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, counters=0, sync flops cleared to 0.
- Reset mid-transfer: takes effect on the next edge. Strobes are released and Db tri-stated immediately. No response is emitted.
- cmd_ready is combinational: it equals (state==IDLE). It is 1 during reset.
- Wait is synchronised through SYNC_STAGES flops to give wait_s. Db input is synchronised through the same number of flops to give db_s.
- All of Astb, Dstb, Wr and the Db drive enable are registered.
- IDLE:
  - Command accepted on cmd_valid && cmd_ready.
  - On acceptance, latch is_addr, write, and wdata.
  - If write, set Wr=0 and drive Db=wdata; else keep Wr=1 and Db=Z.
  - Clear counter. Go to SETUP.
- SETUP: count SETUP_CYCLES clocks, then assert the selected strobe (Astb or Dstb = 0). Clear counter. Go to STROBE.
- STROBE: wait for wait_s=1.
  - If wait_s=1: for a read go to CAPTURE; for a write, release the strobe and go to RELEASE.
  - If the counter reaches TIMEOUT_CYCLES first: set timeout flag, release the strobe, go to RELEASE.
- CAPTURE (reads only, exactly 1 clock): latch rdata=db_s, release the strobe, go to RELEASE. This extra clock guarantees Db has passed the synchroniser after Wait.
- RELEASE: strobe is high. Wait for wait_s=0, or TIMEOUT_CYCLES (sets timeout flag).
  - On exit: Wr=1, Db=Z.
  - Wr and Db stay held until Wait falls, so write data is held through the peripheral's release.
  - Go to DONE.
- DONE (1 clock):
  - rsp_valid=1.
  - rsp_rdata = latched rdata if read and no timeout, else 0.
  - rsp_timeout = timeout flag.
  - Go to IDLE. The next command can be accepted on the following clock.
- Only one strobe is ever low. Astb and Dstb are never low simultaneously. Strobes are never low while in IDLE.
- Wr is never changed while a strobe is low.
- Wait already high on entry to STROBE (stuck peripheral) is accepted as a handshake. The following RELEASE still requires Wait low or a timeout.
- Counters saturate. Width is clog2(TIMEOUT_CYCLES+1).
- Minimum latency, instant peripheral, write: acceptance to rsp_valid = SETUP_CYCLES + 2*SYNC_STAGES + 3 clocks. Reads take 1 more clock.

Test Plan:
- Address write 0x5A; responder raises Wait 3 clk after Astb falls and drops it 3 clk after Astb rises → Wr=0 and Db=0x5A throughout, Astb low only after 2 clk setup, rsp_valid with timeout=0, rdata=0.
- Data read; responder drives Db=0xC3 and raises Wait on Dstb low → Wr=1 and Db not driven by host, rsp_rdata=0xC3, rsp_timeout=0.
- Wait stuck 0, data write 0x11, TIMEOUT_CYCLES=8 → Dstb low exactly 8 clk then high, rsp_timeout=1, rdata=0, returns to IDLE.
- Wait stuck 1 after a good handshake → RELEASE times out, rsp_timeout=1, strobes high, Wr=1.
- Back-to-back: addr write 0x03, data write 0xFF, data read (responder returns 0x42) with cmd_valid held → three responses in order, cmd_ready low between, strobes never overlap.
- rst asserted while in STROBE of a write → next clk Astb=Dstb=Wr=1, Db=Z, no rsp_valid, cmd_ready=1.
